// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a small prefetch FIFO, pc tagging
// and redirect flush that drains in-flight responses.
module fetch_unit #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int TW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TLAST   = TW'(MAX_OUTSTANDING - 1);
  logic [31:0]   fetch_pc;
  logic [CW-1:0] fifo_count, outstanding, discard;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] tag_wr, tag_rd;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc [DEPTH];
  logic [31:0]   tag_q [MAX_OUTSTANDING];
  logic          grant, push, pop;
  assign mem_req     = !RST && !redirect && (outstanding < MAXO_C) && (fifo_count + outstanding < DEPTH_C);
  assign mem_addr    = fetch_pc[31:2];
  assign grant       = mem_req && mem_gnt;
  assign push        = mem_rvalid && discard == '0 && !redirect;
  assign instr_valid = fifo_count != '0;
  assign pop         = instr_valid && instr_ready;
  assign instr       = instr_valid ? fifo_instr[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr] : '0;
  // Discarded responses never pop a tag: the tag queue is cleared on redirect
  // so only live requests occupy it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc    <= RESET_PC;
      fifo_count  <= '0;
      outstanding <= '0;
      discard     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(mem_rvalid);
      if (redirect) begin
        fetch_pc   <= redirect_pc & ~32'd3;
        discard    <= outstanding - CW'(mem_rvalid);
        fifo_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        tag_wr     <= '0;
        tag_rd     <= '0;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (mem_rvalid && discard != '0) discard <= discard - 1'b1;
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (grant) tag_wr <= tag_wr == TLAST ? '0 : tag_wr + 1'b1;
        if (push) tag_rd <= tag_rd == TLAST ? '0 : tag_rd + 1'b1;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_instr[wr_ptr] <= mem_rdata;
      fifo_pc[wr_ptr]    <= tag_q[tag_rd];
    end
    if (grant) tag_q[tag_wr] <= fetch_pc;
  end
  always_ff @(posedge CLK) begin
    if (!RST && mem_rvalid) assert (outstanding != '0) else $error("rvalid with no outstanding request");
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a fixed-latency
// in-order memory that returns the word address as data.
module tb_fetch_unit;
  logic        CLK = 1'b0;
  logic        RST, mem_req, mem_gnt, mem_rvalid, instr_valid, instr_ready, redirect;
  logic [29:0] mem_addr;
  logic [31:0] mem_rdata, instr, instr_pc, redirect_pc;
  int          checks = 0, failures = 0, lat = 1, cyc = 0;
  logic [29:0] q_addr [$];
  int          q_due [$];

  fetch_unit dut (
    .CLK(CLK), .RST(RST), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 CLK = ~CLK;

  // Memory: grants sampled mid-cycle, data returned lat cycles after grant.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        q_addr.delete();
        q_due.delete();
      end else if (mem_req && mem_gnt) begin
        q_addr.push_back(mem_addr);
        q_due.push_back(cyc + lat);
      end
      @(posedge CLK);
      #1;
      cyc++;
      if (q_due.size() != 0 && q_due[0] <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = {2'b00, q_addr.pop_front()};
        void'(q_due.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
    end
  end

  task automatic nxt();
    @(posedge CLK);
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rst_go(input int l, input logic rdy);
    RST = 1'b1;
    redirect = 1'b0;
    instr_ready = rdy;
    lat = l;
    nxt();
    nxt();
    RST = 1'b0;
    #1;
  endtask

  initial begin
    RST = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    mem_gnt = 1'b1;
    nxt();
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    nxt();
    RST = 1'b0;
    instr_ready = 1'b1;
    #1;
    chk("c0_valid", 32'(instr_valid), 0);
    chk("c0_instr", instr, 0);
    chk("c0_pc", instr_pc, 0);
    chk("c0_req", 32'(mem_req), 1);
    chk("c0_addr", 32'(mem_addr), 0);
    nxt();
    chk("c1_valid", 32'(instr_valid), 0);
    for (int k = 0; k < 4; k++) begin
      nxt();
      chk("stream_valid", 32'(instr_valid), 1);
      chk("stream_pc", instr_pc, 32'(4 * k));
      chk("stream_instr", instr, 32'(k));
    end

    rst_go(1, 1'b0);
    repeat (4) nxt();
    chk("full_req_c4", 32'(mem_req), 0);
    repeat (6) nxt();
    chk("stall_valid", 32'(instr_valid), 1);
    chk("stall_pc", instr_pc, 0);
    chk("stall_req", 32'(mem_req), 0);
    instr_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_valid", 32'(instr_valid), 1);
      chk("drain_pc", instr_pc, 32'(4 * k));
      chk("drain_instr", instr, 32'(k));
      nxt();
    end

    rst_go(3, 1'b1);
    chk("lat_addr0", 32'(mem_addr), 0);
    nxt();
    chk("lat_addr1", 32'(mem_addr), 1);
    chk("lat_req1", 32'(mem_req), 1);
    nxt();
    chk("lat_maxout", 32'(mem_req), 0);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    #1;
    chk("redir_req", 32'(mem_req), 0);
    nxt();
    redirect = 1'b0;
    #1;
    chk("drain_req", 32'(mem_req), 0);
    chk("drain_valid3", 32'(instr_valid), 0);
    nxt();
    chk("refetch_req", 32'(mem_req), 1);
    chk("refetch_addr", 32'(mem_addr), 32'h40);
    for (int k = 0; k < 4; k++) begin
      chk("no_stale", 32'(instr_valid), 0);
      nxt();
    end
    chk("tgt_valid", 32'(instr_valid), 1);
    chk("tgt_pc", instr_pc, 32'h100);
    chk("tgt_instr", instr, 32'h40);
    nxt();
    chk("tgt_pc2", instr_pc, 32'h104);
    chk("tgt_instr2", instr, 32'h41);

    rst_go(1, 1'b1);
    repeat (4) nxt();
    redirect = 1'b1;
    redirect_pc = 32'h203;
    #1;
    chk("hs_valid", 32'(instr_valid), 1);
    chk("hs_pc", instr_pc, 32'h8);
    chk("hs_req", 32'(mem_req), 0);
    nxt();
    redirect = 1'b0;
    #1;
    chk("r203_valid", 32'(instr_valid), 0);
    chk("r203_req", 32'(mem_req), 1);
    chk("r203_addr", 32'(mem_addr), 32'h80);
    nxt();
    chk("r203_valid2", 32'(instr_valid), 0);
    nxt();
    chk("r203_pc", instr_pc, 32'h200);
    chk("r203_instr", instr, 32'h80);
    nxt();
    chk("r203_pc2", instr_pc, 32'h204);
    nxt();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    nxt();
    redirect = 1'b0;
    #1;
    chk("wrap_addr_hi", 32'(mem_addr), 32'h3FFF_FFFF);
    chk("wrap_req", 32'(mem_req), 1);
    nxt();
    chk("wrap_addr0", 32'(mem_addr), 0);
    chk("wrap_valid0", 32'(instr_valid), 0);
    nxt();
    chk("wrap_pc_hi", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_instr_hi", instr, 32'h3FFF_FFFF);
    nxt();
    chk("wrap_pc0", instr_pc, 0);
    chk("wrap_instr0", instr, 0);

    instr_ready = 1'b0;
    #1;
    repeat (8) nxt();
    chk("mid_full_valid", 32'(instr_valid), 1);
    chk("mid_full_req", 32'(mem_req), 0);
    chk("mid_full_pc", instr_pc, 0);
    RST = 1'b1;
    #1;
    chk("mid_rst_req", 32'(mem_req), 0);
    nxt();
    chk("mid_rst_valid", 32'(instr_valid), 0);
    chk("mid_rst_req2", 32'(mem_req), 0);
    chk("mid_rst_instr", instr, 0);
    nxt();
    RST = 1'b0;
    instr_ready = 1'b1;
    #1;
    chk("restart_req", 32'(mem_req), 1);
    chk("restart_addr", 32'(mem_addr), 0);
    chk("restart_valid", 32'(instr_valid), 0);
    nxt();
    nxt();
    chk("restart_pc_valid", 32'(instr_valid), 1);
    chk("restart_pc", instr_pc, 0);
    nxt();
    chk("restart_pc2", instr_pc, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
